// File: rtl/lieat_exu_cmt_queue_pkg.sv
// Shared definitions for the commit queue.
// Holds the default data/PC width, destination register index width and
// queue depth, plus the entry width helper. Entry field layout, MSB first:
//     {ebreak, rdwen, rd[REG_IDX-1:0], pc[XLEN-1:0], data[XLEN-1:0]}
package lieat_exu_cmt_queue_pkg;

    localparam int CMT_XLEN    = 32;
    localparam int CMT_REG_IDX = 5;
    localparam int CMT_DEPTH   = 4;

    // Total width of one stored entry.
    function automatic int cmt_entry_w(input int xlen, input int reg_idx);
        return 2 + reg_idx + 2 * xlen;
    endfunction

endpackage

// File: rtl/lieat_exu_cmt_queue_if.sv
// Commit queue bus bundle.
// Groups the execute-side input handshake, the writeback-side output
// handshake, the occupancy/halt status and the front-end redirect request.
//   slave  : used by the queue (takes i_*, o_ready, flush_sh)
//   master : used by the surrounding pipeline / testbench
interface lieat_exu_cmt_queue_if
    import lieat_exu_cmt_queue_pkg::*;
#(
    parameter int XLEN    = CMT_XLEN,
    parameter int REG_IDX = CMT_REG_IDX,
    parameter int DEPTH   = CMT_DEPTH
);
    logic                     i_valid;
    logic                     i_ready;
    logic [XLEN-1:0]          i_pc;
    logic [REG_IDX-1:0]       i_rd;
    logic                     i_rdwen;
    logic [XLEN-1:0]          i_data;
    logic                     i_ebreak;
    logic                     i_redirect;
    logic [XLEN-1:0]          i_redirect_pc;

    logic                     o_valid;
    logic                     o_ready;
    logic [XLEN-1:0]          o_pc;
    logic [REG_IDX-1:0]       o_rd;
    logic                     o_wen;
    logic [XLEN-1:0]          o_data;
    logic                     o_ebreak;
    logic [$clog2(DEPTH):0]   o_count;

    logic                     flush_req;
    logic [XLEN-1:0]          flush_pc;
    logic                     flush_sh;
    logic                     halted;

    modport slave (
        input  i_valid, i_pc, i_rd, i_rdwen, i_data, i_ebreak, i_redirect, i_redirect_pc,
        output i_ready,
        output o_valid, o_pc, o_rd, o_wen, o_data, o_ebreak, o_count,
        input  o_ready,
        output flush_req, flush_pc, halted,
        input  flush_sh
    );

    modport master (
        output i_valid, i_pc, i_rd, i_rdwen, i_data, i_ebreak, i_redirect, i_redirect_pc,
        input  i_ready,
        input  o_valid, o_pc, o_rd, o_wen, o_data, o_ebreak, o_count,
        output o_ready,
        input  flush_req, flush_pc, halted,
        output flush_sh
    );

endinterface

// File: rtl/lieat_exu_cmt_ram.sv
// Commit queue storage: DEPTH x DW register array.
// One synchronous write port, one asynchronous read port. All entries
// reset to zero.
//   wen_i/waddr_i/wdata_i : write port
//   raddr_i/rdata_o       : combinational read port
module lieat_exu_cmt_ram #(
    parameter int DEPTH = 4,
    parameter int DW    = 71
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wen_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        lieat_general_dfflr #(.DW(DW)) u_entry (
            .clock  (clock),
            .reset  (reset),
            .lden_i (wen_i & (waddr_i == AW'(i))),
            .dnxt_i (wdata_i),
            .qout_o (mem_q[i])
        );
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lieat_general_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to zero.
//   clock, reset : clock and async active-low reset
//   lden_i       : load enable
//   dnxt_i       : next value
//   qout_o       : registered value
module lieat_general_dfflr #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            qout_o <= '0;
        end else if (lden_i) begin
            qout_o <= dnxt_i;
        end
    end

endmodule

// File: rtl/lieat_exu_cmt_queue.sv
// In-order commit queue between the execute units and register writeback.
// Buffers up to DEPTH completed instructions and owns the front-end redirect
// request: a redirect is latched when its instruction is enqueued and held
// until flush_sh; anything arriving while it is pending is wrong-path and is
// dropped (accepted on the handshake, never written). An accepted ebreak
// halts all further input until reset.
//
// Ports:
//   clock, reset  : sole clock, asynchronous active-low reset
//   bus (slave)   : i_* execute input handshake, o_* writeback output
//                   handshake, o_count, flush_req/flush_pc/flush_sh, halted
//
// Build option COM_BYPASS_EN: when the queue is empty and no redirect is
// pending, a valid input is presented on o_* in the same cycle and, if taken,
// never written. Undefined: one-cycle minimum latency, no input-to-output
// data path.
module lieat_exu_cmt_queue
    import lieat_exu_cmt_queue_pkg::*;
#(
    parameter int XLEN    = CMT_XLEN,
    parameter int REG_IDX = CMT_REG_IDX,
    parameter int DEPTH   = CMT_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    lieat_exu_cmt_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = cmt_entry_w(XLEN, REG_IDX);

    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            flush_req_q, flush_req_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;
    logic            halted_q, halted_d;

    logic [EW-1:0]   in_entry, head_entry, out_entry;
    logic            full, empty, bypass;
    logic            o_valid_w, i_ready_w;
    logic            in_sh, out_sh, accept, wr_en, rd_en;
    logic            redirect_set, flush_clr;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign in_entry = {bus.i_ebreak, bus.i_rdwen, bus.i_rd, bus.i_pc, bus.i_data};

`ifdef COM_BYPASS_EN
    assign bypass    = empty & ~flush_req_q & bus.i_valid;
    assign out_entry = bypass ? in_entry : head_entry;
`else
    assign bypass    = 1'b0;
    assign out_entry = head_entry;
`endif

    // o_valid never looks at o_ready, so out_sh -> i_ready is loop-free.
    assign o_valid_w = ~empty | bypass;
    assign out_sh    = o_valid_w & bus.o_ready;
    assign i_ready_w = ~halted_q & (flush_req_q | ~full | out_sh);
    assign in_sh     = bus.i_valid & i_ready_w;

    // accept: a real (right-path) enqueue; in_sh while a redirect is
    // pending is a drop.
    assign accept = in_sh & ~flush_req_q;
    // A bypassed entry taken in the same cycle never touches storage.
    assign wr_en  = accept & ~(bypass & bus.o_ready);
    assign rd_en  = out_sh & ~bypass;

    assign wptr_d  = wptr_q + AW'(1);
    assign rptr_d  = rptr_q + AW'(1);
    assign count_d = count_q + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, rd_en};

    // set requires flush_req_q==0 and clear requires flush_req_q==1, so
    // they never coincide.
    assign redirect_set = accept & bus.i_redirect;
    assign flush_clr    = bus.flush_sh & flush_req_q;
    assign flush_req_d  = redirect_set | (flush_req_q & ~flush_clr);
    assign flush_pc_d   = bus.i_redirect_pc;
    assign halted_d     = halted_q | (accept & bus.i_ebreak);

    lieat_general_dfflr #(.DW(AW)) u_wptr (
        .clock(clock), .reset(reset), .lden_i(wr_en), .dnxt_i(wptr_d), .qout_o(wptr_q)
    );
    lieat_general_dfflr #(.DW(AW)) u_rptr (
        .clock(clock), .reset(reset), .lden_i(rd_en), .dnxt_i(rptr_d), .qout_o(rptr_q)
    );
    lieat_general_dfflr #(.DW(CW)) u_count (
        .clock(clock), .reset(reset), .lden_i(wr_en ^ rd_en), .dnxt_i(count_d), .qout_o(count_q)
    );
    lieat_general_dfflr #(.DW(1)) u_flush_req (
        .clock(clock), .reset(reset), .lden_i(1'b1), .dnxt_i(flush_req_d), .qout_o(flush_req_q)
    );
    lieat_general_dfflr #(.DW(XLEN)) u_flush_pc (
        .clock(clock), .reset(reset), .lden_i(redirect_set), .dnxt_i(flush_pc_d), .qout_o(flush_pc_q)
    );
    lieat_general_dfflr #(.DW(1)) u_halted (
        .clock(clock), .reset(reset), .lden_i(1'b1), .dnxt_i(halted_d), .qout_o(halted_q)
    );

    lieat_exu_cmt_ram #(.DEPTH(DEPTH), .DW(EW)) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wen_i   (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (in_entry),
        .raddr_i (rptr_q),
        .rdata_o (head_entry)
    );

    assign {bus.o_ebreak, bus.o_wen, bus.o_rd, bus.o_pc, bus.o_data} = out_entry;

    assign bus.o_valid   = o_valid_w;
    assign bus.i_ready   = i_ready_w;
    assign bus.o_count   = count_q;
    assign bus.flush_req = flush_req_q;
    assign bus.flush_pc  = flush_pc_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_lieat_exu_cmt_queue.sv
module tb_lieat_exu_cmt_queue;
    import lieat_exu_cmt_queue_pkg::*;

    localparam int XLEN    = CMT_XLEN;
    localparam int REG_IDX = CMT_REG_IDX;
    localparam int DEPTH   = CMT_DEPTH;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    lieat_exu_cmt_queue_if #(.XLEN(XLEN), .REG_IDX(REG_IDX), .DEPTH(DEPTH)) bus ();

    lieat_exu_cmt_queue #(.XLEN(XLEN), .REG_IDX(REG_IDX), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        ebreak;
    } ent_t;

    ent_t        mq[$];
    bit          m_freq = 0;
    bit          m_halt = 0;
    logic [31:0] m_fpc  = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO plus redirect/halt flags, updated once
    // per cycle from the handshakes that the rules say happen at the edge.
    always @(negedge clock) begin : cmp
        bit   outs, exp_ir, ins, nf;
        ent_t e;
        if (!reset) begin
            mq.delete();
            m_freq = 0;
            m_halt = 0;
            m_fpc  = '0;
            chk("rst_o_valid",   bus.o_valid,   0);
            chk("rst_o_count",   bus.o_count,   0);
            chk("rst_flush_req", bus.flush_req, 0);
            chk("rst_flush_pc",  bus.flush_pc,  0);
            chk("rst_halted",    bus.halted,    0);
            chk("rst_i_ready",   bus.i_ready,   1);
        end else begin
            outs   = (mq.size() > 0) && bus.o_ready;
            exp_ir = !m_halt && (m_freq || (mq.size() < DEPTH) || outs);
            chk("i_ready",   bus.i_ready,   exp_ir);
            chk("o_valid",   bus.o_valid,   mq.size() > 0);
            chk("o_count",   bus.o_count,   mq.size());
            chk("flush_req", bus.flush_req, m_freq);
            chk("flush_pc",  bus.flush_pc,  m_fpc);
            chk("halted",    bus.halted,    m_halt);
            if (mq.size() > 0) begin
                chk("o_pc",     bus.o_pc,     mq[0].pc);
                chk("o_rd",     bus.o_rd,     mq[0].rd);
                chk("o_wen",    bus.o_wen,    mq[0].wen);
                chk("o_data",   bus.o_data,   mq[0].data);
                chk("o_ebreak", bus.o_ebreak, mq[0].ebreak);
            end
            ins = bus.i_valid && exp_ir;
            nf  = m_freq;
            if (outs) void'(mq.pop_front());
            if (m_freq && bus.flush_sh) nf = 0;
            if (ins && !m_freq) begin
                e.pc = bus.i_pc; e.rd = bus.i_rd; e.wen = bus.i_rdwen;
                e.data = bus.i_data; e.ebreak = bus.i_ebreak;
                mq.push_back(e);
                if (bus.i_redirect) begin
                    nf    = 1;
                    m_fpc = bus.i_redirect_pc;
                end
                if (bus.i_ebreak) m_halt = 1;
            end
            m_freq = nf;
        end
    end

    task automatic step(input bit v, input logic [31:0] pc, input bit eb, input bit rdr,
                        input logic [31:0] rpc, input bit ordy, input bit fsh);
        @(posedge clock);
        #1;
        bus.i_valid       = v;
        bus.i_pc          = pc;
        bus.i_rd          = pc[6:2];
        bus.i_rdwen       = ~pc[2];
        bus.i_data        = pc * 3 + 32'h1000;
        bus.i_ebreak      = eb;
        bus.i_redirect    = rdr;
        bus.i_redirect_pc = rpc;
        bus.o_ready       = ordy;
        bus.flush_sh      = fsh;
    endtask

    task automatic idle(input bit ordy);
        step(0, 32'h0, 0, 0, 32'h0, ordy, 0);
    endtask

    task automatic push(input logic [31:0] pc, input bit ordy);
        step(1, pc, 0, 0, 32'h0, ordy, 0);
    endtask

    task automatic peek();
        @(negedge clock);
        #1;
    endtask

    initial begin
        bus.i_valid = 0; bus.i_pc = '0; bus.i_rd = '0; bus.i_rdwen = 0;
        bus.i_data = '0; bus.i_ebreak = 0; bus.i_redirect = 0;
        bus.i_redirect_pc = '0; bus.o_ready = 0; bus.flush_sh = 0;

        idle(0);
        idle(0);
        peek();
        chk("lit_rst_count",  bus.o_count, 0);
        chk("lit_rst_iready", bus.i_ready, 1);
        @(posedge clock); #1 reset = 1'b1;

        // Fill: fifth entry is refused once four are held.
        for (int i = 0; i < 5; i++) push(32'h100 + 4 * i, 0);
        peek();
        chk("lit_fill_iready", bus.i_ready, 0);
        chk("lit_fill_count",  bus.o_count, 4);
        chk("lit_fill_pc",     bus.o_pc,    32'h100);

        // Full plus pop in the same cycle.
        push(32'h110, 1);
        peek();
        chk("lit_fullpop_iready", bus.i_ready, 1);
        chk("lit_fullpop_count",  bus.o_count, 4);
        push(32'h114, 1);
        peek();
        chk("lit_fullpop_next_pc", bus.o_pc,    32'h104);
        chk("lit_fullpop_next_ct", bus.o_count, 4);
        push(32'h118, 1);
        push(32'h11C, 1);
        for (int i = 0; i < 4; i++) idle(1);
        idle(0);
        peek();
        chk("lit_drained_count", bus.o_count, 0);

        // Redirect: C and D are wrong-path and dropped.
        push(32'h200, 0);
        step(1, 32'h204, 0, 1, 32'h8000_0040, 0, 0);
        push(32'h208, 0);
        peek();
        chk("lit_redir_req",   bus.flush_req, 1);
        chk("lit_redir_pc",    bus.flush_pc,  32'h8000_0040);
        chk("lit_redir_count", bus.o_count,   2);
        push(32'h20C, 0);
        // Acknowledge with E presented: E is still dropped.
        step(1, 32'h210, 0, 0, 32'h0, 0, 1);
        peek();
        chk("lit_ack_req_same", bus.flush_req, 1);
        push(32'h214, 0);
        peek();
        chk("lit_ack_req_next", bus.flush_req, 0);
        chk("lit_ack_count",    bus.o_count,   2);
        idle(1);
        peek();
        chk("lit_commit_a", bus.o_pc,    32'h200);
        chk("lit_commit_n", bus.o_count, 3);
        idle(1);
        peek();
        chk("lit_commit_b", bus.o_pc, 32'h204);
        idle(1);
        peek();
        chk("lit_commit_f", bus.o_pc, 32'h214);
        idle(0);

        // Halt: ebreak entry (also carrying a redirect) stops further input.
        push(32'h2F0, 0);
        step(1, 32'h300, 1, 1, 32'h9000_0000, 0, 0);
        push(32'h304, 0);
        peek();
        chk("lit_halt_halted", bus.halted,    1);
        chk("lit_halt_iready", bus.i_ready,   0);
        chk("lit_halt_count",  bus.o_count,   2);
        chk("lit_halt_freq",   bus.flush_req, 1);
        idle(1);
        idle(0);
        peek();
        chk("lit_halt_ebreak", bus.o_ebreak, 1);
        chk("lit_halt_pc",     bus.o_pc,     32'h300);

        // Asynchronous reset mid-cycle clears entries, redirect and halt.
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("lit_async_count",  bus.o_count,   0);
        chk("lit_async_valid",  bus.o_valid,   0);
        chk("lit_async_halted", bus.halted,    0);
        chk("lit_async_freq",   bus.flush_req, 0);
        chk("lit_async_iready", bus.i_ready,   1);
        @(posedge clock); #1 reset = 1'b1;

        push(32'h400, 0);
        idle(1);
        peek();
        chk("lit_post_pc",    bus.o_pc,    32'h400);
        chk("lit_post_count", bus.o_count, 1);
        idle(0);
        peek();
        chk("lit_post_empty", bus.o_count, 0);
        idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
